// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the cpu_sequencer slice: FSM state encoding,
// architectural widths, the halt encoding and the instruction field bit positions.
package cpu_seq_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] HALT_INSTR = 32'h0000_0000;

    // Field slices handed to the datapath decoder
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 21;
    localparam int RM_HI  = 20;
    localparam int RM_LO  = 16;
    localparam int RN_HI  = 9;
    localparam int RN_LO  = 5;
    localparam int RD_HI  = 4;
    localparam int RD_LO  = 0;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT,
        ST_FAULT
    } seq_state_t;

endpackage

// File: rtl/imem_fetch_if.sv
// Instruction-memory request/ack handshake: drives the request while the FSM is
// fetching, reports completion, and flags a timeout when the ack never arrives.
module imem_fetch_if
    import cpu_seq_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic [XLEN-1:0] fetch_addr,
    input  logic            imem_ack,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic            done,
    output logic            timeout
);

    logic [7:0] wait_cnt_reg;
    logic [7:0] wait_cnt_next;

    // Counts unacknowledged request cycles; restarts whenever a fetch is not pending.
    always_comb begin
        wait_cnt_next = '0;
        if (fetch_en && !imem_ack) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // The fetch address is the PC, which only moves in EXEC, so it is stable until ack.
    assign imem_req  = fetch_en;
    assign imem_addr = fetch_addr;
    assign done      = fetch_en & imem_ack;
    assign timeout   = fetch_en & ~imem_ack & (wait_cnt_reg == 8'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer around the single-cycle datapath.
// Optional retired-instruction counter built only when SEQ_INSTRET_EN is defined.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET      = 64'h0,
    parameter int              INIT_CYCLES   = 2,
    parameter int              FETCH_TIMEOUT = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic            step,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            cpu_meminit,
    output logic            cpu_exec,
    output logic [XLEN-1:0] cpu_instruction,
    output logic [10:0]     cpu_instr_31_21,
    output logic [4:0]      cpu_instr_20_16,
    output logic [4:0]      cpu_instr_9_5,
    output logic [4:0]      cpu_instr_4_0,
    output logic [XLEN-1:0] cpu_pc,
    input  logic [XLEN-1:0] cpu_nextpc,
    output logic            busy,
    output logic            halted,
    output logic            fault,
    output logic [31:0]     instret
);

    seq_state_t      state_reg, state_next;
    logic [XLEN-1:0] pc_reg;
    logic [ILEN-1:0] instr_reg;
    logic [7:0]      init_cnt_reg, init_cnt_next;
    logic            single_step_reg, single_step_next;
    logic            pc_load;
    logic            instr_load;
    logic            fetch_done;
    logic            fetch_timeout;

    imem_fetch_if #(
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) u_fetch (
        .clock     (clock),
        .reset     (reset),
        .fetch_en  (state_reg == ST_FETCH),
        .fetch_addr(pc_reg),
        .imem_ack  (imem_ack),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .done      (fetch_done),
        .timeout   (fetch_timeout)
    );

    always_comb begin
        state_next       = state_reg;
        init_cnt_next    = init_cnt_reg;
        single_step_next = single_step_reg;
        pc_load          = 1'b0;
        instr_load       = 1'b0;
        case (state_reg)
            ST_INIT: begin
                if (init_cnt_reg == 8'(INIT_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    init_cnt_next = init_cnt_reg + 8'd1;
                end
            end
            ST_IDLE: begin
                // run takes precedence over a simultaneous step
                if (run) begin
                    state_next       = ST_FETCH;
                    single_step_next = 1'b0;
                end else if (step) begin
                    state_next       = ST_FETCH;
                    single_step_next = 1'b1;
                end
            end
            ST_FETCH: begin
                if (fetch_done) begin
                    instr_load = 1'b1;
                    state_next = (imem_rdata == HALT_INSTR) ? ST_HALT : ST_EXEC;
                end else if (fetch_timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_EXEC: begin
                if (cpu_nextpc[1:0] != 2'b00) begin
                    state_next = ST_FAULT;
                end else begin
                    pc_load    = 1'b1;
                    state_next = (run && !single_step_reg) ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT:  state_next = ST_HALT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_INIT;
            pc_reg          <= PC_RESET;
            instr_reg       <= '0;
            init_cnt_reg    <= '0;
            single_step_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            init_cnt_reg    <= init_cnt_next;
            single_step_reg <= single_step_next;
            if (pc_load) begin
                pc_reg <= cpu_nextpc;
            end
            if (instr_load) begin
                instr_reg <= imem_rdata;
            end
        end
    end

`ifdef SEQ_INSTRET_EN
    logic [31:0] instret_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            instret_reg <= '0;
        end else if (pc_load) begin
            instret_reg <= instret_reg + 32'd1;
        end
    end

    assign instret = instret_reg;
`else
    assign instret = 32'h0;
`endif

    assign cpu_meminit     = (state_reg == ST_INIT);
    assign cpu_exec        = (state_reg == ST_EXEC);
    assign busy            = (state_reg == ST_FETCH) || (state_reg == ST_EXEC);
    assign halted          = (state_reg == ST_HALT);
    assign fault           = (state_reg == ST_FAULT);
    assign cpu_pc          = pc_reg;
    assign cpu_instruction = {32'h0, instr_reg};
    assign cpu_instr_31_21 = instr_reg[OPC_HI:OPC_LO];
    assign cpu_instr_20_16 = instr_reg[RM_HI:RM_LO];
    assign cpu_instr_9_5   = instr_reg[RN_HI:RN_LO];
    assign cpu_instr_4_0   = instr_reg[RD_HI:RD_LO];

endmodule
